key_sw_input_port: RTL and testbench



---
 rtl/io_map_pkg.sv | 17 +
 rtl/debounce_bit.sv | 48 ++++
 rtl/key_sw_input_port.sv | 60 ++++++
 tb/tb_key_sw_input_port.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// I/O address map shared by the output registers and the input port.
// The whole I/O decode is kept here so every responder agrees on it.
package io_map_pkg;

    localparam int IO_BASE_BIT    = 9;
    localparam int IO_LED_BIT     = 2;
    localparam int IO_HEX_BIT     = 3;
    localparam int IO_KEY_BIT     = 4;
    localparam int IO_SW_BIT      = 5;
    localparam int IO_KEYEDGE_BIT = 6;

    // True when addr falls in I/O space and the given select bit is set
    function automatic logic io_sel(input logic [31:0] addr, input int sel_bit);
        return addr[IO_BASE_BIT] & addr[sel_bit];
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchroniser followed by a counter debouncer for one input bit.
// fall pulses in the cycle the stable value commits a 1->0 transition.
module debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;
    logic          commit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    assign commit = (sync2 != stable) && (cnt == CNT_MAX);
    assign fall   = commit & ~sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= RESET_VAL;
            cnt    <= '0;
        end else if (sync2 == stable) begin
            cnt    <= '0;
        end else if (commit) begin
            stable <= sync2;
            cnt    <= '0;
        end else begin
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/key_sw_input_port.sv
// Memory-mapped key/switch input responder: debounced levels, sticky
// write-1-to-clear key-press flags and a combinational I/O read path.
module key_sw_input_port
    import io_map_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int KEY_W           = 4,
    parameter int SW_W            = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [KEY_W-1:0] key_raw,
    input  logic [SW_W-1:0]  sw_raw,
    input  logic [31:0]      addr,
    input  logic             memwrite,
    input  logic [31:0]      writedata,
    output logic [31:0]      io_readdata,
    output logic             key_irq
);

    logic [KEY_W-1:0] key_stable, key_fall, edge_flags, clr_mask;
    logic [SW_W-1:0]  sw_stable, sw_fall_unused;

    for (genvar i = 0; i < KEY_W; i++) begin : g_key
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_db (
            .clk(clk), .reset_n(reset_n), .din(key_raw[i]),
            .stable(key_stable[i]), .fall(key_fall[i])
        );
    end

    for (genvar i = 0; i < SW_W; i++) begin : g_sw
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_db (
            .clk(clk), .reset_n(reset_n), .din(sw_raw[i]),
            .stable(sw_stable[i]), .fall(sw_fall_unused[i])
        );
    end

    assign clr_mask = (memwrite && io_sel(addr, IO_KEYEDGE_BIT)) ? writedata[KEY_W-1:0] : '0;

    // New presses are OR-ed in after the clear so a same-cycle set wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_flags <= '0;
        else          edge_flags <= (edge_flags & ~clr_mask) | key_fall;
    end

    assign key_irq = |edge_flags;

    always_comb begin
        io_readdata = '0;
        if (addr[IO_BASE_BIT]) begin
            if (addr[IO_KEY_BIT])          io_readdata = 32'(key_stable);
            else if (addr[IO_SW_BIT])      io_readdata = 32'(sw_stable);
            else if (addr[IO_KEYEDGE_BIT]) io_readdata = 32'(edge_flags);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{writedata[31:KEY_W], sw_fall_unused};

endmodule

// File: tb/tb_key_sw_input_port.sv
// Directed bench for key_sw_input_port: reset, debounce latency, glitch
// rejection, edge flags with write-1-to-clear and mid-debounce reset.
module tb_key_sw_input_port;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  key_raw;
    logic [9:0]  sw_raw;
    logic [31:0] addr, writedata, io_readdata, d;
    logic        memwrite, key_irq;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] A_KEY = 32'h210, A_SW = 32'h220, A_EDGE = 32'h240;

    key_sw_input_port dut (
        .clk(clk), .reset_n(reset_n), .key_raw(key_raw), .sw_raw(sw_raw),
        .addr(addr), .memwrite(memwrite), .writedata(writedata),
        .io_readdata(io_readdata), .key_irq(key_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = io_readdata;
    endtask

    task automatic wr_at_next_edge(input logic [31:0] a, input logic [31:0] v);
        addr = a; writedata = v; memwrite = 1'b1;
        step(1);
        memwrite = 1'b0; writedata = '0;
    endtask

    initial begin
        reset_n = 1'b0; key_raw = 4'hF; sw_raw = '0;
        addr = '0; writedata = '0; memwrite = 1'b0;
        step(2);
        rd(A_KEY, d); chk("rst_in_key", d, 32'hF);
        reset_n = 1'b1;
        step(1);

        // 1: reset values
        rd(A_KEY, d);  chk("reset_key", d, 32'hF);
        rd(A_SW, d);   chk("reset_sw", d, 32'h0);
        rd(A_EDGE, d); chk("reset_edge", d, 32'h0);
        chk("reset_irq", 32'(key_irq), 32'h0);
        rd(32'h010, d); chk("no_io_base", d, 32'h0);

        // 2: switch latency is 2 + 4 cycles
        sw_raw = 10'h2A5;
        for (int i = 1; i <= 5; i++) begin
            step(1);
            rd(A_SW, d); chk($sformatf("sw_lat_c%0d", i), d, 32'h0);
        end
        step(1);
        rd(A_SW, d); chk("sw_lat_c6", d, 32'h2A5);
        rd(32'h230, d); chk("key_over_sw", d, 32'hF);
        rd(32'h260, d); chk("sw_over_edge", d, 32'h2A5);
        rd(32'h020, d); chk("sw_no_base", d, 32'h0);

        // 3: a 3-cycle glitch never reaches stable
        key_raw = 4'b1101;
        step(3);
        key_raw = 4'hF;
        for (int i = 0; i < 6; i++) begin
            step(1);
            rd(A_KEY, d); chk("glitch_key", d, 32'hF);
        end
        rd(A_EDGE, d); chk("glitch_edge", d, 32'h0);

        // 4: held press sets a sticky flag
        key_raw = 4'b1011;
        step(10);
        rd(A_KEY, d);  chk("press_key", d, 32'hB);
        rd(A_EDGE, d); chk("press_edge", d, 32'h4);
        chk("press_irq", 32'(key_irq), 32'h1);
        key_raw = 4'hF;
        step(10);
        rd(A_KEY, d);  chk("rel_key", d, 32'hF);
        rd(A_EDGE, d); chk("rel_edge", d, 32'h4);
        chk("rel_irq", 32'(key_irq), 32'h1);

        // ignored writes: sw/key addresses and outside I/O space
        wr_at_next_edge(A_KEY, 32'hF);
        wr_at_next_edge(32'h040, 32'hF);
        rd(A_EDGE, d); chk("ignored_wr", d, 32'h4);

        // 5: clear flag 2 on the edge key 0 commits its press
        key_raw = 4'b1110;
        step(5);
        rd(A_KEY, d); chk("k0_before_commit", d, 32'hF);
        wr_at_next_edge(A_EDGE, 32'h4);
        rd(A_EDGE, d); chk("clr2_set0", d, 32'h1);
        rd(A_KEY, d);  chk("k0_pressed", d, 32'hE);
        key_raw = 4'hF;
        step(8);
        rd(A_EDGE, d); chk("k0_rel_sticky", d, 32'h1);
        key_raw = 4'b1110;
        step(5);
        wr_at_next_edge(A_EDGE, 32'h1);
        rd(A_EDGE, d); chk("set_wins", d, 32'h1);
        wr_at_next_edge(A_EDGE, 32'h1);
        rd(A_EDGE, d); chk("plain_clear", d, 32'h0);
        chk("irq_cleared", 32'(key_irq), 32'h0);
        key_raw = 4'hF;
        step(8);

        // 6: reset mid-debounce with a flag set
        key_raw = 4'b0111;
        step(10);
        rd(A_EDGE, d); chk("k3_flag", d, 32'h8);
        sw_raw = 10'h155;
        step(3);
        reset_n = 1'b0;
        key_raw = 4'hF;
        rd(A_KEY, d);  chk("rst2_key", d, 32'hF);
        rd(A_SW, d);   chk("rst2_sw", d, 32'h0);
        rd(A_EDGE, d); chk("rst2_edge", d, 32'h0);
        chk("rst2_irq", 32'(key_irq), 32'h0);
        step(2);
        reset_n = 1'b1;
        step(5);
        rd(A_SW, d); chk("post_rst_c5", d, 32'h0);
        step(1);
        rd(A_SW, d); chk("post_rst_c6", d, 32'h155);
        rd(A_EDGE, d); chk("post_rst_edge", d, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
